// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner of a shared 8:1 single-bit mux: grants one requester at a time for up to HOLD_MAX cycles.
// Optional macro MUX_SCHED_LOCK_EN adds a 'lock' input that keeps the current tenure open indefinitely.
module mux8_rr_scheduler #(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef MUX_SCHED_LOCK_EN
   input  logic       lock,
`endif
   input  logic [7:0] req,
   input  logic [7:0] in,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       busy,
   output logic       y
);

   localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     r_state;
   logic [2:0] r_ptr;
   logic [7:0] r_cnt;
   logic [7:0] r_gnt;
   logic [2:0] r_sel;
   logic       r_y;

   logic [2:0] w_start;
   logic [2:0] w_winner;
   logic       w_found;
   logic       w_expire;
   logic       w_release;
   logic [7:0] w_cntNext;

   // On release the scan starts just after the holder, so the holder itself is checked last.
   always_comb begin
      w_start  = (r_state == GRANT) ? r_sel + 3'd1 : r_ptr;
      w_found  = 1'b0;
      w_winner = w_start;
      for (int i = 7; i >= 0; i--) begin
         if (req[w_start + 3'(i)]) begin
            w_found  = 1'b1;
            w_winner = w_start + 3'(i);
         end
      end
   end

   always_comb begin
`ifdef MUX_SCHED_LOCK_EN
      w_expire = (r_cnt == CNT_LAST) && !lock;
`else
      w_expire = (r_cnt == CNT_LAST);
`endif
      w_release = !req[r_sel] || w_expire;
      w_cntNext = (r_cnt == CNT_LAST) ? r_cnt : r_cnt + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= 3'd0;
         r_cnt   <= 8'd0;
         r_gnt   <= 8'd0;
         r_sel   <= 3'd0;
         r_y     <= 1'b0;
      end else begin
         r_y <= (r_state == GRANT) ? in[r_sel] : 1'b0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_gnt   <= 8'd1 << w_winner;
                  r_sel   <= w_winner;
                  r_cnt   <= 8'd0;
                  r_state <= GRANT;
               end else begin
                  r_gnt <= 8'd0;
               end
            end
            GRANT: begin
               if (!w_release) begin
                  r_cnt <= w_cntNext;
               end else begin
                  r_ptr <= r_sel + 3'd1;
                  if (w_found) begin
                     r_gnt <= 8'd1 << w_winner;
                     r_sel <= w_winner;
                     r_cnt <= 8'd0;
                  end else begin
                     r_gnt   <= 8'd0;
                     r_state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign gnt  = r_gnt;
   assign sel  = r_sel;
   assign busy = (r_state == GRANT);
   assign y    = r_y;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed self-checking bench for mux8_rr_scheduler (HOLD_MAX=4, lane data 8'b10101010).
module tb_mux8_rr_scheduler;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] in;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;
   logic       y;
`ifdef MUX_SCHED_LOCK_EN
   logic       lock;
`endif

   int nCompared;
   int nFailed;

   mux8_rr_scheduler #(.HOLD_MAX(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
`ifdef MUX_SCHED_LOCK_EN
      .lock (lock),
`endif
      .req  (req),
      .in   (in),
      .gnt  (gnt),
      .sel  (sel),
      .busy (busy),
      .y    (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs, let one rising edge pass, then settle 1 time unit before sampling.
   task automatic applyStimulus(input logic [7:0] r, input logic [7:0] d);
      req = r;
      in  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected)
      else begin
         nFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [7:0] eGnt, input logic [2:0] eSel,
                           input logic eBusy, input logic eY);
      checkOutput({tag, ".gnt"}, 32'(gnt), 32'(eGnt));
      checkOutput({tag, ".sel"}, 32'(sel), 32'(eSel));
      checkOutput({tag, ".busy"}, 32'(busy), 32'(eBusy));
      checkOutput({tag, ".y"}, 32'(y), 32'(eY));
   endtask

   localparam logic [7:0] DATA = 8'b10101010;

   initial begin
      logic [2:0] expSel;
      logic [2:0] prevSel;
      nCompared = 0;
      nFailed   = 0;
`ifdef MUX_SCHED_LOCK_EN
      lock = 1'b0;
`endif

      // Reset held for two edges with everything requesting.
      rst_n = 1'b0;
      applyStimulus(8'hFF, 8'hFF);
      applyStimulus(8'hFF, 8'hFF);
      checkAll("reset", 8'h00, 3'd0, 1'b0, 1'b0);

      // First edge after reset grants lane 0 with y still low.
      rst_n = 1'b1;
      applyStimulus(8'hFF, DATA);
      checkAll("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

      // Full rotation: each lane holds 4 cycles, y follows previous cycle's lane bit.
      for (int t = 1; t < 36; t++) begin
         applyStimulus(8'hFF, DATA);
         expSel  = 3'((t / 4) % 8);
         prevSel = 3'(((t - 1) / 4) % 8);
         checkAll($sformatf("rotate_t%0d", t), 8'd1 << expSel, expSel, 1'b1, DATA[prevSel]);
      end

      // Single requester on lane 3: regranted across expiries, never drops.
      for (int j = 0; j < 12; j++) begin
         applyStimulus(8'h08, DATA);
         checkAll($sformatf("single_c%0d", j), 8'h08, 3'd3, 1'b1, (j == 0) ? 1'b0 : 1'b1);
      end

      // All requests drop: back to idle, sel keeps the last grantee.
      applyStimulus(8'h00, DATA);
      checkAll("go_idle", 8'h00, 3'd3, 1'b0, 1'b1);

      // Early release: lane 2 granted, then drops while lane 5 waits.
      applyStimulus(8'h04, DATA);
      checkAll("grant_lane2", 8'h04, 3'd2, 1'b1, 1'b0);
      applyStimulus(8'h04, DATA);
      checkAll("hold_lane2", 8'h04, 3'd2, 1'b1, 1'b0);
      applyStimulus(8'h20, DATA);
      checkAll("early_rel_5", 8'h20, 3'd5, 1'b1, 1'b0);

      // Wrap: holder 7 releases with lanes 1 and 6 requesting -> lane 1 wins.
      applyStimulus(8'h80, DATA);
      checkAll("grant_lane7", 8'h80, 3'd7, 1'b1, 1'b1);
      applyStimulus(8'h42, DATA);
      checkAll("wrap_to_1", 8'h02, 3'd1, 1'b1, 1'b1);

      // Reset mid-tenure on lane 5.
      applyStimulus(8'h20, DATA);
      checkAll("grant_lane5", 8'h20, 3'd5, 1'b1, 1'b1);
      applyStimulus(8'h20, DATA);
      checkAll("hold_lane5", 8'h20, 3'd5, 1'b1, 1'b1);
      rst_n = 1'b0;
      applyStimulus(8'h20, DATA);
      checkAll("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);

      // Pointer was cleared, so lane 0 beats lane 5 and keeps it for a full tenure.
      rst_n = 1'b1;
      applyStimulus(8'h21, DATA);
      checkAll("post_reset_0", 8'h01, 3'd0, 1'b1, 1'b0);
      for (int k = 1; k < 4; k++) begin
         applyStimulus(8'h21, DATA);
         checkAll($sformatf("hold0_c%0d", k), 8'h01, 3'd0, 1'b1, 1'b0);
      end
      applyStimulus(8'h21, DATA);
      checkAll("expire_to_5", 8'h20, 3'd5, 1'b1, 1'b0);
      applyStimulus(8'h21, DATA);
      checkAll("lane5_y", 8'h20, 3'd5, 1'b1, 1'b1);

`ifdef MUX_SCHED_LOCK_EN
      // Lock keeps lane 5 past its limit; unlocking releases on the next cycle.
      lock = 1'b1;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(8'hFF, DATA);
         checkAll($sformatf("locked_c%0d", k), 8'h20, 3'd5, 1'b1, 1'b1);
      end
      lock = 1'b0;
      applyStimulus(8'hFF, DATA);
      checkAll("unlock_to_6", 8'h40, 3'd6, 1'b1, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule

// File: doc/mux8_rr_scheduler.md
Name: mux8_rr_scheduler

Overview:
- Round-robin scheduler that shares one 8:1 single-bit mux path among 8 requesters.
- Each requester raises a req bit. The block grants one requester at a time, drives the mux select, and returns the selected lane as a registered output.
- A grant is held until the requester drops req or a tenure limit expires.
- Sits in front of the 8:1 mux as its sequencing/ownership controller.

Parameters:
- HOLD_MAX, 4, maximum consecutive granted cycles per tenure; legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- req  input  8  request per lane; bit i = requester i
- in  input  8  mux data lanes; bit i belongs to requester i
- gnt  output  8  one-hot grant, registered; all-zero when idle
- sel  output  3  mux select, registered; index of current/last grantee
- busy  output  1  high while a grant is active
- y  output  1  registered mux output

Behaviour:
- Reset: when rst_n=0 at a clk edge: gnt=0, sel=0, busy=0, y=0, internal ptr=0, cnt=0. Reset overrides every other event, including mid-tenure.
- Internal state:
  - ptr (3b): highest-priority index for the next arbitration.
  - cnt (8b): cycles elapsed in the current tenure.
  - FSM states: IDLE (busy=0) and GRANT (busy=1).
- IDLE:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ... mod 8.
  - At the next edge: gnt=onehot(winner), sel=winner, busy=1, cnt=0, state=GRANT. Grant latency is 1 cycle from req sampled.
  - If req==0: stay IDLE; gnt=0; sel holds its last value.
- GRANT, evaluated every cycle:
  - drop = !req[sel].
  - expire = (cnt==HOLD_MAX-1).
  - release = drop | expire.
  - No release: cnt<=cnt+1; gnt/sel unchanged.
  - Release: ptr<=sel+1 (7 wraps to 0). Re-arbitrate the same cycle over req, scanning sel+1..sel+7, then sel last. The current holder is regranted only if it is the sole requester and still has req high.
  - Winner found: gnt/sel updated at that edge, cnt=0, remain GRANT (no bubble).
  - No winner: gnt=0, busy=0, state=IDLE.
- HOLD_MAX=1: re-arbitration every cycle; pure per-cycle round robin.
- Data path: each edge, y<=in[sel] when busy=1, else y<=0.
  - y lags sel/gnt by one cycle.
  - y is 0 in the first cycle of busy after IDLE.
- Requests arriving mid-tenure never preempt; they wait for release.
- req bits are level-sensitive. Clearing req on a lane not granted has no effect.
- gnt is always one-hot or zero. busy==(gnt!=0).

Optional Feature:
- Macro: MUX_SCHED_LOCK_EN.
- Defined: adds input lock (1b).
  - While busy=1 and lock=1, expire is forced 0; the tenure is unlimited and cnt saturates at HOLD_MAX-1.
  - drop still releases.
  - lock has no effect in IDLE.
- Undefined: no lock port; tenure always bounded by HOLD_MAX.

Test Plan:
- Reset: rst_n=0 for 2 edges with req=8'hFF, in=8'hFF -> gnt=0, sel=0, busy=0, y=0. First edge after rst_n=1 -> gnt=8'h01, sel=0.
- Single requester: req=8'h08 held 12 cycles, HOLD_MAX=4, in=8'b10101010 -> gnt=8'h08, sel=3 one cycle after req. Regranted every 4 cycles (cnt returns to 0), gnt never drops, y=1 from the second busy cycle onward.
- Full rotation: req=8'hFF constant, HOLD_MAX=4, in=8'b10101010 -> sel sequence 0,1,2,...,7,0, each held 4 cycles. y alternates 0/1 per tenure, delayed one cycle. No idle gaps between tenures.
- Early release and wrap:
  - Grant on lane 2; deassert req[2] after 1 cycle with req[5]=1 -> next edge gnt=8'h20, sel=5.
  - Then holder 7 releases with req=8'b01000010 -> next grant is lane 1, not 6.
- Reset mid-tenure: rst_n=0 for one edge while busy with sel=5 -> gnt=0, busy=0, y=0, sel=0.
  - After release with req=8'h21, lane 0 is granted first (ptr reset to 0).
- Lock (MUX_SCHED_LOCK_EN defined): HOLD_MAX=2, lane 4 granted, lock=1, req=8'hFF for 10 cycles -> gnt stays 8'h10.
  - lock=0 -> release at next expiry, lane 5 granted.
